// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler output-port serializer.
package nibbler_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int FRAME_BITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/nibble_fifo.sv
// Synchronous nibble FIFO; a push on a full FIFO is accepted only when a pop
// happens on the same edge.
module nibble_fifo
    import nibbler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [NIBBLE_W-1:0]       din,
    output logic [NIBBLE_W-1:0]       dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [NIBBLE_W-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/nibble_out_tx.sv
// Nibbler output port: queues CPU nibbles and sends each as a start bit,
// four data bits LSB first and a stop bit on txd.
module nibble_out_tx
    import nibbler_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadOut,
    input  logic [3:0] D,
    input  logic       clr_ovf,
    output logic       txd,
    output logic       busy,
    output logic       full,
    output logic       overflow,
    output logic [1:0] dbg_state
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_t             state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [1:0]            bit_q, bit_d;
    logic [NIBBLE_W-1:0]   shift_q, shift_d;
    logic                  overflow_q, overflow_d;
    logic                  pop;
    logic                  baud_wrap;
    logic                  drop;
    logic [NIBBLE_W-1:0]   fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Handshake: loadOut is a valid-only strobe with no ready, because the core
    // cannot stall; a write that finds the FIFO full with no same-edge pop is
    // dropped and recorded in overflow.
    nibble_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (loadOut),
        .pop   (pop),
        .din   (D),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign drop      = loadOut && fifo_full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd     = 1'b1;
        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (baud_wrap) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd = shift_q[0];
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 2'd1;
                    if (bit_q == 2'd3) state_d = STOP;
                end
            end
            STOP: begin
                // Popping on the last stop cycle keeps back-to-back frames gapless.
                if (baud_wrap) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign full      = fifo_full;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_out_tx.sv
// Directed bench for nibble_out_tx: vector table of single frames plus
// hand-written multi-frame, overflow, full-with-pop and reset sequences.
module tb_nibble_out_tx;
    import nibbler_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       loadOut;
    logic [3:0] D;
    logic       clr_ovf;
    logic       txd;
    logic       busy;
    logic       full;
    logic       overflow;
    logic [1:0] dbg_state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] d;
    } drv_t;

    typedef struct {
        logic [3:0] d;
        logic [5:0] frame;
    } vec_t;

    drv_t       drv_q[$];
    drv_t       cur;
    logic [3:0] exp_q[$];
    vec_t       vecs[6];

    nibble_out_tx #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .loadOut   (loadOut),
        .D         (D),
        .clr_ovf   (clr_ovf),
        .txd       (txd),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    // Entries queued at posedge time are applied one per negedge, so entry j
    // is sampled by the j-th rising edge after queuing.
    initial begin
        forever begin
            @(negedge clk);
            if (drv_q.size() > 0) begin
                cur     = drv_q.pop_front();
                loadOut = cur.en;
                D       = cur.d;
            end
        end
    end

    task automatic enq(input logic en, input logic [3:0] d);
        drv_q.push_back({en, d});
    endtask

    task automatic enq_idle(input int n);
        for (int i = 0; i < n; i++) drv_q.push_back({1'b0, 4'h0});
    endtask

    // Returns at the negedge just after the edge that samples the first entry.
    task automatic sync_ref();
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [5:0] frame_of(input logic [3:0] d);
        return {1'b0, d[0], d[1], d[2], d[3], 1'b1};
    endfunction

    function automatic logic [23:0] expand(input logic [5:0] f);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 4; j++)
                r[23 - (i*4 + j)] = f[5 - i];
        return r;
    endfunction

    task automatic capture(output logic [23:0] s);
        s = '0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            s[23 - i] = txd;
        end
    endtask

    task automatic check_frames(input int nframes, input string name);
        logic [23:0] s;
        logic [23:0] e;
        for (int f = 0; f < nframes; f++) begin
            capture(s);
            if (exp_q.size() > 0) e = expand(frame_of(exp_q.pop_front()));
            else                  e = 24'hFFFFFF;
            check($sformatf("%s_frame%0d", name, f), 32'(s), 32'(e));
        end
    endtask

    // ---------------- test ----------------
    initial begin
        logic [23:0] s;
        bit          bad;

        vecs[0] = '{4'hA, 6'b001011};
        vecs[1] = '{4'h0, 6'b000001};
        vecs[2] = '{4'hF, 6'b011111};
        vecs[3] = '{4'h1, 6'b010001};
        vecs[4] = '{4'h8, 6'b000011};
        vecs[5] = '{4'h6, 6'b001101};

        rst_n   = 1'b0;
        loadOut = 1'b0;
        D       = 4'h0;
        clr_ovf = 1'b0;

        // Reset held with loadOut toggling: outputs stay idle, nothing queued.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            loadOut = ~loadOut;
            D       = 4'(i);
            check($sformatf("rst_hold%0d", i), {txd, busy, full, overflow}, 4'b1000);
        end
        check("rst_state", dbg_state, 2'b00);
        @(negedge clk);
        loadOut = 1'b0;
        rst_n   = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {txd, busy, full, overflow}, 4'b1000);

        // Table: one write, one frame, busy drops one cycle after the last stop cycle.
        for (int v = 0; v < 6; v++) begin
            @(posedge clk);
            enq(1'b1, vecs[v].d);
            enq_idle(1);
            sync_ref();
            check($sformatf("vec%0d_lat", v), txd, 1'b1);
            capture(s);
            check($sformatf("vec%0d_frame", v), 32'(s), 32'(expand(vecs[v].frame)));
            check($sformatf("vec%0d_busy_last", v), busy, 1'b1);
            @(negedge clk);
            check($sformatf("vec%0d_busy_end", v), {busy, txd}, 2'b01);
            repeat (3) @(negedge clk);
        end

        // Two writes on consecutive edges: contiguous frames.
        @(posedge clk);
        enq(1'b1, 4'h3);
        enq(1'b1, 4'hC);
        enq_idle(1);
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hC);
        sync_ref();
        check_frames(2, "b2b");
        @(negedge clk);
        check("b2b_busy_end", busy, 1'b0);
        repeat (3) @(negedge clk);

        // Six writes from idle: fifth fills the FIFO, sixth is dropped.
        @(posedge clk);
        enq(1'b1, 4'h1);
        enq(1'b1, 4'h2);
        enq(1'b1, 4'h4);
        enq(1'b1, 4'h8);
        enq(1'b1, 4'h5);
        enq(1'b1, 4'h7);
        enq_idle(1);
        exp_q.push_back(4'h1);
        exp_q.push_back(4'h2);
        exp_q.push_back(4'h4);
        exp_q.push_back(4'h8);
        exp_q.push_back(4'h5);
        sync_ref();
        fork
            check_frames(5, "ovf");
            begin
                repeat (3) @(negedge clk);
                check("ovf_full_n3", {full, overflow}, 2'b00);
                @(negedge clk);
                check("ovf_full_n4", {full, overflow}, 2'b10);
                @(negedge clk);
                check("ovf_set", {full, overflow}, 2'b11);
            end
        join
        @(negedge clk);
        check("ovf_sticky_idle", {busy, overflow}, 2'b01);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("ovf_clear", overflow, 1'b0);
        repeat (3) @(negedge clk);

        // FIFO full with a write on the end-of-stop pop edge: accepted.
        @(posedge clk);
        enq(1'b1, 4'h9);
        enq_idle(1);
        enq(1'b1, 4'h2);
        enq(1'b1, 4'hB);
        enq(1'b1, 4'hD);
        enq(1'b1, 4'hE);
        enq_idle(19);
        enq(1'b1, 4'h6);
        enq_idle(1);
        exp_q.push_back(4'h9);
        exp_q.push_back(4'h2);
        exp_q.push_back(4'hB);
        exp_q.push_back(4'hD);
        exp_q.push_back(4'hE);
        exp_q.push_back(4'h6);
        sync_ref();
        fork
            check_frames(6, "fullpop");
            begin
                repeat (5) @(negedge clk);
                check("fullpop_full_n5", {full, overflow}, 2'b10);
                repeat (19) @(negedge clk);
                check("fullpop_pre", {full, overflow}, 2'b10);
                @(negedge clk);
                check("fullpop_post", {full, overflow}, 2'b10);
            end
        join
        @(negedge clk);
        check("fullpop_busy_end", {busy, overflow}, 2'b00);
        repeat (3) @(negedge clk);

        // Reset asserted during data bit 2: line returns high at once, no resume.
        @(posedge clk);
        enq(1'b1, 4'h3);
        enq_idle(1);
        sync_ref();
        repeat (14) @(negedge clk);
        check("rst_mid_pre", {txd, busy}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", {txd, busy}, 2'b10);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("rst_mid_quiet50", bad, 1'b0);

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
